// File: rtl/asyn_fifo_pkg.sv
// asyn_fifo shared definitions.
// Default geometry and Gray-code helper.
package asyn_fifo_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 8;

    typedef logic [31:0] word_t;

    function automatic word_t bin2gray(input word_t b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// asyn_fifo storage: DEPTH x DATA_W array,
// synchronous write, registered read port.
module fifo_mem
    import asyn_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Array is deliberately not reset
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // Read-before-write: same-address write returns old data
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/asyn_fifo.sv
// Single-clock FIFO with binary pointers and
// registered Gray copies driving full/empty.
module asyn_fifo
    import asyn_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] dout,
    input  logic [DATA_W-1:0] din,
    input  logic              wclk,
    input  logic              wrst,
    input  logic              wen,
    input  logic              ren
);

    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0] FULL_X =
        PW'(3) << (ADDR_W - 1);

    logic [PW-1:0] wptr, rptr;
    logic [PW-1:0] wgray, rgray;
    logic [PW-1:0] wptr_n, rptr_n;
    logic          wr_ok, rd_ok;

    assign empty = (wgray == rgray);
    assign full  = ((wgray ^ rgray) == FULL_X);

    // A read while full frees the slot the write lands in
    assign rd_ok = ren && !empty;
    assign wr_ok = wen && (!full || ren);

    assign wptr_n = wptr + PW'(wr_ok);
    assign rptr_n = rptr + PW'(rd_ok);

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wptr  <= '0;
            rptr  <= '0;
            wgray <= '0;
            rgray <= '0;
        end else begin
            wptr  <= wptr_n;
            rptr  <= rptr_n;
            wgray <= PW'(bin2gray(word_t'(wptr_n)));
            rgray <= PW'(bin2gray(word_t'(rptr_n)));
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk    (wclk),
        .rst    (wrst),
        .we     (wr_ok),
        .waddr  (wptr[ADDR_W-1:0]),
        .wdata  (din),
        .re     (rd_ok),
        .raddr  (rptr[ADDR_W-1:0]),
        .rdata  (dout)
    );

endmodule

// File: tb/tb_asyn_fifo.sv
// Scoreboard bench for asyn_fifo: driver queues expected
// read data, monitor checks dout on the following negedge.
module tb_asyn_fifo;

    localparam int DW = 8;
    localparam int DP = 8;

    logic          wclk = 1'b0;
    logic          wrst = 1'b1;
    logic          wen  = 1'b0;
    logic          ren  = 1'b0;
    logic [DW-1:0] din  = '0;
    logic          full, empty;
    logic [DW-1:0] dout;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_dout = '0;

    asyn_fifo #(.DATA_W(DW), .DEPTH(DP)) dut (
        .full  (full),
        .empty (empty),
        .dout  (dout),
        .din   (din),
        .wclk  (wclk),
        .wrst  (wrst),
        .wen   (wen),
        .ren   (ren)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(negedge wclk) begin
        if (exp_q.size() > 0) begin
            logic [DW-1:0] v;
            v = exp_q.pop_front();
            chk("dout_read", int'(dout), int'(v));
        end
    end

    task automatic check_flags(input string tag);
        chk({tag, "_empty"}, int'(empty), int'(model_q.size() == 0));
        chk({tag, "_full"}, int'(full), int'(model_q.size() == DP));
    endtask

    task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d);
        logic rd, wr;
        wen = w;
        ren = r;
        din = d;
        @(posedge wclk);
        #1;
        rd = r && (model_q.size() > 0);
        wr = w && ((model_q.size() < DP) || rd);
        if (rd) begin
            last_dout = model_q.pop_front();
            exp_q.push_back(last_dout);
        end else begin
            chk("dout_hold", int'(dout), int'(last_dout));
        end
        if (wr)
            model_q.push_back(d);
        wen = 1'b0;
        ren = 1'b0;
        check_flags("cyc");
    endtask

    task automatic drain();
        while (model_q.size() > 0)
            cycle(1'b0, 1'b1, 8'h00);
    endtask

    initial begin
        // reset then idle
        repeat (2) @(posedge wclk);
        #1;
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_dout", int'(dout), 0);
        @(negedge wclk);
        wrst = 1'b0;
        repeat (2) cycle(1'b0, 1'b0, 8'h00);
        chk("idle_dout", int'(dout), 0);

        // fill, overflow attempt, drain in order
        for (int i = 0; i < DP; i++)
            cycle(1'b1, 1'b0, 8'(8'h02 + i));
        chk("fill_full", int'(full), 1);
        cycle(1'b1, 1'b0, 8'h0A);
        chk("ovf_full", int'(full), 1);
        drain();
        chk("drain_empty", int'(empty), 1);

        // simultaneous read/write from empty
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 1'b1, 8'(8'h02 + i));
            chk("rw_nofull", int'(full), 0);
        end
        drain();

        // full with simultaneous read/write
        for (int i = 0; i < DP; i++)
            cycle(1'b1, 1'b0, 8'(8'h02 + i));
        cycle(1'b1, 1'b1, 8'hAA);
        chk("fullrw_dout", int'(dout), 8'h02);
        chk("fullrw_full", int'(full), 1);
        drain();
        chk("fullrw_last", int'(dout), 8'hAA);

        // read on empty
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b1, 8'h00);
        chk("rdempty_dout", int'(dout), 8'hAA);

        // reset with 5 entries stored
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 1'b0, 8'(8'h30 + i));
        #2 wrst = 1'b1;
        #1;
        chk("midrst_empty", int'(empty), 1);
        chk("midrst_full", int'(full), 0);
        chk("midrst_dout", int'(dout), 0);
        model_q.delete();
        last_dout = '0;
        #3 wrst = 1'b0;
        cycle(1'b1, 1'b0, 8'h55);
        cycle(1'b0, 1'b1, 8'h00);
        @(negedge wclk);
        #1;
        chk("post_rst_dout", int'(dout), 8'h55);
        chk("post_rst_empty", int'(empty), 1);
        chk("exp_q_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
